// File: rtl/div_if.sv
// Pipeline <-> divider handshake: operands and control from EXE, stall/ready/result back.
interface div_if;
   logic        div_start_i;
   logic        div_signed_i;
   logic [31:0] div_opdata1_i;
   logic [31:0] div_opdata2_i;
   logic        div_cancel_i;
   logic        stallreq_o;
   logic        div_ready_o;
   logic [63:0] div_result_o;

   modport master (
      output div_start_i, div_signed_i, div_opdata1_i, div_opdata2_i, div_cancel_i,
      input  stallreq_o, div_ready_o, div_result_o
   );

   modport slave (
      input  div_start_i, div_signed_i, div_opdata1_i, div_opdata2_i, div_cancel_i,
      output stallreq_o, div_ready_o, div_result_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up on completion.
module div_ctrl (
   input  logic cpu_clk_50M,
   input  logic cpu_rst_n,
   div_if.slave div_bus
);

   typedef enum logic [1:0] {
      IDLE_S = 2'd0,
      BUSY_S = 2'd1,
      DONE_S = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [4:0]  cnt_r;
   logic        signed_r;
   logic        sign1_r;
   logic        sign2_r;
   logic [31:0] quot_r;
   logic [31:0] divisor_r;
   logic [31:0] rem_r;
   logic        ready_r;
   logic [63:0] result_r;

   logic        accept_s;
   logic [32:0] trial_s;
   logic        ge_s;
   logic [31:0] rem_next_s;
   logic [31:0] quot_next_s;
   logic [31:0] quot_fix_s;
   logic [31:0] rem_fix_s;
   logic        stall_s;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      neg32 = (~v) + 32'd1;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      abs32 = (is_signed & v[31]) ? neg32(v) : v;
   endfunction

   // State register
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_r <= IDLE_S;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; cancel has priority over completion
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE_S: begin
            if (accept_s) begin
               next_state_s = (div_bus.div_opdata2_i == 32'd0) ? DONE_S : BUSY_S;
            end else begin
               next_state_s = IDLE_S;
            end
         end
         BUSY_S: begin
            if (div_bus.div_cancel_i) begin
               next_state_s = IDLE_S;
            end else if (cnt_r == 5'd31) begin
               next_state_s = DONE_S;
            end else begin
               next_state_s = BUSY_S;
            end
         end
         DONE_S:  next_state_s = IDLE_S;
         default: next_state_s = IDLE_S;
      endcase
   end

   // Stall request output decode
   always_comb begin
      stall_s = 1'b0;
      case (state_r)
         IDLE_S:  stall_s = accept_s;
         BUSY_S:  stall_s = ~div_bus.div_cancel_i;
         DONE_S:  stall_s = 1'b0;
         default: stall_s = 1'b0;
      endcase
   end

   // One restoring step: 33-bit trial remainder against the zero-extended divisor
   always_comb begin
      accept_s    = div_bus.div_start_i & ~div_bus.div_cancel_i;
      trial_s     = {rem_r, quot_r[31]};
      ge_s        = (trial_s >= {1'b0, divisor_r});
      rem_next_s  = ge_s ? (trial_s[31:0] - divisor_r) : trial_s[31:0];
      quot_next_s = {quot_r[30:0], ge_s};
      quot_fix_s  = (signed_r & (sign1_r ^ sign2_r)) ? neg32(quot_next_s) : quot_next_s;
      rem_fix_s   = (signed_r & sign1_r) ? neg32(rem_next_s) : rem_next_s;
   end

   // Operand capture and iteration datapath
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         cnt_r     <= 5'd0;
         signed_r  <= 1'b0;
         sign1_r   <= 1'b0;
         sign2_r   <= 1'b0;
         quot_r    <= 32'd0;
         divisor_r <= 32'd0;
         rem_r     <= 32'd0;
      end else begin
         case (state_r)
            IDLE_S: begin
               if (accept_s) begin
                  cnt_r     <= 5'd0;
                  signed_r  <= div_bus.div_signed_i;
                  sign1_r   <= div_bus.div_opdata1_i[31];
                  sign2_r   <= div_bus.div_opdata2_i[31];
                  quot_r    <= abs32(div_bus.div_opdata1_i, div_bus.div_signed_i);
                  divisor_r <= abs32(div_bus.div_opdata2_i, div_bus.div_signed_i);
                  rem_r     <= 32'd0;
               end
            end
            BUSY_S: begin
               if (!div_bus.div_cancel_i) begin
                  cnt_r  <= cnt_r + 5'd1;
                  quot_r <= quot_next_s;
                  rem_r  <= rem_next_s;
               end
            end
            DONE_S: begin
               cnt_r <= 5'd0;
            end
            default: begin
               cnt_r <= 5'd0;
            end
         endcase
      end
   end

   // Registered ready pulse and result; both are zero outside DONE
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         ready_r  <= 1'b0;
         result_r <= 64'd0;
      end else begin
         ready_r <= (next_state_s == DONE_S);
         if ((state_r == BUSY_S) && (next_state_s == DONE_S)) begin
            result_r <= {rem_fix_s, quot_fix_s};
         end else begin
            result_r <= 64'd0;
         end
      end
   end

   assign div_bus.stallreq_o   = stall_s;
   assign div_bus.div_ready_o  = ready_r;
   assign div_bus.div_result_o = result_r;

endmodule
